// File: rtl/sd_arbiter.sv
// sd_arbiter: round-robin two-port arbiter in front of the SD block cache, with a transaction watchdog.
// One transaction at a time; ready/error pulses are returned only to the granted port.
module sd_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq0_read,
    input  logic        rq0_write,
    input  logic [31:0] rq0_addr,
    input  logic [7:0]  rq0_wdata,
    output logic [7:0]  rq0_rdata,
    output logic        rq0_ready,
    output logic        rq0_error,
    input  logic        rq1_read,
    input  logic        rq1_write,
    input  logic [31:0] rq1_addr,
    input  logic [7:0]  rq1_wdata,
    output logic [7:0]  rq1_rdata,
    output logic        rq1_ready,
    output logic        rq1_error,
    output logic        cache_read,
    output logic        cache_write,
    output logic [31:0] cache_addr,
    output logic [7:0]  cache_wdata,
    input  logic [7:0]  cache_rdata,
    input  logic        cache_ready,
    output logic        grant,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t      state;
    logic        last_grant;
    logic        op_write;
    logic [23:0] counter;
    logic        pend0, pend1, sel, timed_out;
    always_comb begin
        pend0     = rq0_read | rq0_write;
        pend1     = rq1_read | rq1_write;
        sel       = (pend0 & pend1) ? ~last_grant : pend1;
        timed_out = (TIMEOUT != 24'd0) && (counter == TIMEOUT - 24'd1);
    end
    // Strobes drop in the ready cycle so the cache never sees a second request.
    assign cache_read  = (state == ISSUE) & ~op_write & ~cache_ready;
    assign cache_write = (state == ISSUE) &  op_write & ~cache_ready;
    assign busy        = (state != IDLE);
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            op_write    <= 1'b0;
            counter     <= 24'd0;
            cache_addr  <= 32'd0;
            cache_wdata <= 8'd0;
            rq0_rdata   <= 8'd0;
            rq1_rdata   <= 8'd0;
            rq0_ready   <= 1'b0;
            rq1_ready   <= 1'b0;
            rq0_error   <= 1'b0;
            rq1_error   <= 1'b0;
        end else begin
            rq0_ready <= 1'b0;
            rq1_ready <= 1'b0;
            rq0_error <= 1'b0;
            rq1_error <= 1'b0;
            case (state)
                IDLE: if (pend0 | pend1) begin
                    op_write    <= sel ? rq1_write : rq0_write;
                    cache_addr  <= sel ? rq1_addr : rq0_addr;
                    cache_wdata <= sel ? rq1_wdata : rq0_wdata;
                    grant       <= sel;
                    last_grant  <= sel;
                    counter     <= 24'd0;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    counter <= counter + 24'd1;
                    if (cache_ready) begin
                        rq0_ready <= ~grant;
                        rq1_ready <= grant;
                        if (!op_write && !grant) rq0_rdata <= cache_rdata;
                        if (!op_write && grant) rq1_rdata <= cache_rdata;
                        state <= DONE;
                    end else if (timed_out) begin
                        rq0_error <= ~grant;
                        rq1_error <= grant;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sd_arbiter.md
# sd_arbiter

Two-port arbiter that shares the single SD-card block cache between the CPU load/store path (port 0) and the boot loader / bulk-transfer engine (port 1). It latches one request at a time, drives the cache's level-sensitive read/write strobes, routes address and write data, and returns the cache's one-cycle ready (and read data) only to the granted requester. Grant is round-robin when both ports are pending. A watchdog aborts any transaction the cache never completes.

## Interface
- TIMEOUT, default 24'hFFFFFF: cycles allowed in ISSUE before abort; 0 disables the watchdog.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- rq0_read / rq0_write  in  1  port 0 request, level, held until rq0_ready or rq0_error.
- rq0_addr  in  32  port 0 byte address.
- rq0_wdata  in  8  port 0 write byte.
- rq0_rdata  out  8  port 0 read byte, valid while rq0_ready=1.
- rq0_ready  out  1  port 0 completion pulse, one cycle.
- rq0_error  out  1  port 0 timeout pulse, one cycle.
- rq1_*: identical set for port 1.
- cache_read / cache_write  out  1  level request to cache.
- cache_addr  out  32  latched address of granted transaction.
- cache_wdata  out  8  latched write byte.
- cache_rdata  in  8  read byte, valid in the cache_ready cycle.
- cache_ready  in  1  cache completion pulse.
- grant  out  1  port owning the current/last transaction.
- busy  out  1  high in ISSUE and DONE.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: pending_n = rqn_read | rqn_write. If none, stay. If one, grant it. If both, grant port != last_grant. On grant: latch op (write wins if both read and write high on a port), addr, wdata; grant <= port; last_grant <= port; counter <= 0; -> ISSUE.
- ISSUE: cache_read = op_is_read & ~cache_ready; cache_write = op_is_write & ~cache_ready (combinational gating, so the cache never sees a request in its ready cycle and does not re-issue). Counter increments each cycle.
  - cache_ready=1: rqG_ready <= 1, rqG_rdata <= cache_rdata (reads only; writes leave rdata unchanged) -> DONE.
  - else if TIMEOUT != 0 and counter == TIMEOUT-1: rqG_error <= 1 -> DONE.
- DONE: ready/error pulse visible this cycle; cache strobes low; requests not sampled; -> IDLE. Requester deasserts during this cycle.
- cache_ready outside ISSUE is ignored (late completion after abort or reset).
- Non-granted port sees no ready/error; its request waits in IDLE.
- cache_addr/cache_wdata hold last latched values in all states.

## Timing
- Reset values: state IDLE, cache_read 0, cache_write 0, cache_addr 0, cache_wdata 0, rq0/1_ready 0, rq0/1_error 0, rq0/1_rdata 0, grant 0, busy 0, counter 0, last_grant 1 (port 0 wins first tie).
- Request seen high in IDLE cycle t -> cache strobe high from t+1.
- cache_ready in cycle c -> rqG_ready and rqG_rdata in c+1 -> IDLE in c+2 -> next grant's strobe earliest c+3.
- Minimum requester-visible latency: cache latency + 2 cycles.
- Timeout: strobe high for exactly TIMEOUT cycles, error in the following cycle.
- Reset in ISSUE/DONE: immediate return to IDLE, strobes low next cycle, no ready/error pulse for the aborted transaction; the in-flight cache op is not cancelled (the cache has no reset), and its ready is ignored.
- Counter 24 bits, does not wrap within TIMEOUT.

## Test plan
- Single read port 0, addr 32'h0000_0200, cache model ready after 5 cycles with rdata 8'hA5 -> cache_read high 5 cycles then low in ready cycle, rq0_ready one cycle later with rq0_rdata 8'hA5, rq1_ready never high.
- Both ports request write in same cycle after reset -> port 0 served first (grant=0), then port 1; next simultaneous pair -> port 1 first (grant alternates).
- Port 1 write addr 32'h0000_1234, wdata 8'h3C, port 0 read arrives mid-transaction -> cache_addr/cache_wdata stay 1234/3C until rq1_ready; port 0 granted 2 cycles after rq1_ready.
- TIMEOUT=16, cache never ready -> cache_read high exactly 16 cycles, rq0_error one pulse, no rq0_ready; late cache_ready afterwards ignored.
- Port 0 asserts read and write together -> cache_write only.
- reset pulsed during ISSUE -> all outputs at reset values next cycle, no ready/error, subsequent request completes normally.
